// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO and its read-side stream stage.
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 16;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
    typedef logic [1:0]            occ_t;

    // A new pop is safe only if the word it returns will still find a free slot
    // after this edge's in-flight capture and stream pop have been accounted for.
    function automatic logic pop_allowed(input occ_t occ, input logic inflight, input logic pop_out);
        logic [2:0] pending;
        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop_out};
        return pending <= 3'd1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer: tail write, head pop, registered head/valid outputs.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output occ_t                  occ_o,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    occ_t                  occ_q, occ_d;
    logic                  valid_q, valid_d;

    // NOTE: every next-state variable gets its hold value first, so no path infers a latch.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (pop_i && occ_q != 2'd0) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
        end
        // Write lands after the pop, so a simultaneous capture at occ==1 becomes the new head.
        if (wr_i && occ_d != 2'd2) begin
            if (occ_d == 2'd0) head_d = wr_data_i;
            else               tail_d = wr_data_i;
            occ_d = occ_d + 2'd1;
        end
        valid_d = (occ_d != 2'd0);
    end

    // NOTE: the two data slots are reset as well, because m_data must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign occ_o   = occ_q;
    assign head_o  = head_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO drain stage: issues pops, absorbs the one-cycle read latency, presents a valid/ready stream.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  rd_err
);

    occ_t                 occ;
    logic                 pop_out;
    logic                 inflight_q;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                 rd_err_q, rd_err_d;

    fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (inflight_q),
        .wr_data_i (fifo_data_out),
        .pop_i     (pop_out),
        .occ_o     (occ),
        .head_o    (m_data),
        .valid_o   (m_valid)
    );

    // m_ready only ever reaches fifo_rd_en; the stream outputs come straight from registers.
    assign pop_out    = m_valid && m_ready;
    assign fifo_rd_en = rst_n && enable && !fifo_empty && pop_allowed(occ, inflight_q, pop_out);

    assign word_cnt_d = word_cnt_q + CNT_WIDTH'(pop_out);
    assign rd_err_d   = rd_err_q || (fifo_rd_en && fifo_empty);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            word_cnt_q <= word_cnt_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign word_cnt = word_cnt_q;
    assign rd_err   = rd_err_q;

`ifdef SIM
    a_occ_range: assert property (@(posedge clk) disable iff (!rst_n) occ <= 2'd2);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_rd_en && fifo_empty));
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        m_valid && !m_ready |=> $stable(m_data) && m_valid);
    a_latency: assert property (@(posedge clk) disable iff (!rst_n) fifo_rd_en |=> ##1 m_valid);
`endif

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Downstream drain stage for the synchronous FIFO. It issues `rd_en` pops and captures the FIFO's registered `data_out` one cycle later. Words are held in a 2-entry skid buffer and presented on a valid/ready stream, so the FIFO's read latency and underflow rules are hidden from consumers. It sits directly after the FIFO's read port in the same clock domain.

## Interface
- `DATA_WIDTH`, 16, word width; equals the FIFO's `FIFO_WIDTH`.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  when low, no new pops are issued; words already in flight are still captured and delivered.
- `fifo_data_out`  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted pop.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  pop request to the FIFO.
- `m_data`  out  DATA_WIDTH  stream data (head of the skid buffer).
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `word_cnt`  out  CNT_WIDTH  words delivered (`m_valid && m_ready`); wraps modulo 2^CNT_WIDTH.
- `rd_err`  out  1  sticky; set if `fifo_rd_en && fifo_empty` is ever sampled.

## Operation
- **Internal state**
  - `occ`, 0..2: skid-buffer occupancy.
  - `inflight`, 0..1: a pop was accepted last edge, and its data appears on `fifo_data_out` this cycle.
- **Pop rule** (combinational): `fifo_rd_en = rst_n && enable && !fifo_empty && (occ + inflight - pop_out) <= 1`, where `pop_out = m_valid && m_ready`.
  - This is the only path from `m_ready` to an output. `m_ready` never reaches `m_valid` or `m_data` combinationally.
- **Each edge**
  - `inflight <= fifo_rd_en`.
  - If `inflight`, write `fifo_data_out` at the buffer tail.
  - If `pop_out`, shift the head out.
  - Simultaneous capture and pop when `occ==1`: the new word becomes head, and `occ` stays 1.
  - Simultaneous capture and pop when `occ==2`: cannot occur, because the pop rule forbids `inflight` at `occ==2`.
- `m_valid = (occ != 0)`; `m_data` = head entry. Both are registered.
- `word_cnt` increments on each `pop_out`; wraps to 0 after 2^CNT_WIDTH-1.
- **Ordering**: words leave in exact FIFO order. No drop, no duplication, no overwrite of buffer entries.
- **Error flag**: `rd_err` is set by `fifo_rd_en && fifo_empty`; it is cleared only by reset. It is unreachable by design and is checked by the bench.

## Timing
- **Reset values** while `rst_n` is low:
  - `fifo_rd_en=0`, `m_valid=0`, `m_data=0`, `word_cnt=0`, `rd_err=0`.
  - `occ=0`, `inflight=0`.
- **Latency**: `fifo_rd_en` high in cycle N (FIFO not empty) gives FIFO data in cycle N+1. The word is captured at the end of N+1, so `m_valid` is high in cycle N+2. First word after the FIFO goes non-empty with an idle buffer: 2 cycles.
- **Throughput**: with `m_ready` held high and the FIFO not empty, one word per cycle sustained (steady state `occ=1`, `inflight=1`).
- **Backpressure**: with `m_ready` low, at most 2 words are held. `fifo_rd_en` deasserts once `occ + inflight == 2`, and `m_data` holds stable while `m_valid && !m_ready`.
- **FIFO empty**: no pop is issued. An in-flight word still lands, and the stream drains normally.
- **`enable` falls mid-burst**: pops stop at that cycle. The one in-flight word is still captured, and `m_valid` stays up until the buffer drains.
- **Reset asserted mid-operation**: all state clears immediately (asynchronous). Buffered and in-flight words are discarded, and no pop is issued in the first cycle after release unless the pop rule holds.
- **FIFO pointer wrap-around**: transparent to this block.

## Structure
- Shared package `fifo_pkg`: `FIFO_WIDTH`, `FIFO_DEPTH` constants and `typedef logic [FIFO_WIDTH-1:0] fifo_word_t`. `DATA_WIDTH` defaults from `FIFO_WIDTH`.
- One sub-module: `fifo_skid_buf`, a 2-entry buffer with `wr`/`pop` inputs and `occ`, `head`, `valid` outputs.
- The top level holds the pop rule, `inflight`, `word_cnt` and `rd_err`.
- SVA under `` `ifdef SIM ``:
  - `occ <= 2`.
  - `!(fifo_rd_en && fifo_empty)`.
  - `m_valid && !m_ready |=> $stable(m_data) && m_valid`.
  - `fifo_rd_en |=> ##1 m_valid`.

## Test plan
- **Single word**: write `0xA5A5` into the FIFO, `enable=1`, `m_ready=1` → `fifo_rd_en` pulses once; `m_valid` rises 2 cycles later with `m_data=0xA5A5`; `word_cnt=1`.
- **Burst of 8**: FIFO filled with `0x0001..0x0008`, `m_ready=1` → 8 consecutive `m_valid` cycles in order, no bubbles after the first word; `word_cnt=8`; FIFO ends empty with `rd_err=0`.
- **Backpressure**: burst of 8 with `m_ready=0` for 10 cycles → exactly 2 pops issued, `m_data=0x0001` held stable. Then `m_ready=1` → the remaining words are delivered in order with no loss.
- **Enable gating**: `enable` drops after 3 pops → no further `fifo_rd_en`; exactly 3 words delivered. Re-enable → words 4..8 follow.
- **Reset mid-burst**: assert `rst_n=0` with `occ=2` and `inflight=1` → `m_valid=0`, `word_cnt=0`, `fifo_rd_en=0` immediately; after release, operation resumes cleanly from new FIFO contents.
- **Counter wrap**: with `CNT_WIDTH=4`, deliver 17 words → `word_cnt` reads 1.
